// File: rtl/afe_tot_meter.sv
// afe_tot_meter
//   Consumes the asynchronous AFE comparator output. COMP is brought into the
//   CLK domain through a 2-FF synchroniser, the time-over-threshold of each
//   pulse is measured in CLK cycles, hits are counted and each ToT result is
//   written into a small first-word-fall-through FIFO for the readout logic.
//
// Optional feature
//   AFE_TOT_TIMESTAMP_EN : adds a free-running TS_WIDTH counter. Its value is
//                          captured when a measurement starts, and every FIFO
//                          entry becomes {ts, tot}.
//
// Ports
//   CLK         in   system clock
//   RESET       in   synchronous active-high reset
//   COMP        in   asynchronous comparator output (high = over threshold)
//   ENABLE      in   arms new measurements (ignored once a pulse is measured)
//   DATA        out  FIFO head, DW bits (zero while the FIFO is empty)
//   DATA_VALID  out  FIFO not empty
//   DATA_READ   in   pop the FIFO head
//   HIT_CNT     out  saturating count of completed hits
//   CNT_CLR     in   clear HIT_CNT and OVERFLOW
//   OVERFLOW    out  sticky: a result was dropped because the FIFO was full
//   BUSY        out  high while a pulse is being measured
module afe_tot_meter #(
  parameter int TOT_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TS_WIDTH   = 16,
`ifdef AFE_TOT_TIMESTAMP_EN
  localparam int DW = TS_WIDTH + TOT_WIDTH
`else
  // TS_WIDTH has no effect without timestamps.
  localparam int DW = TOT_WIDTH + 0 * TS_WIDTH
`endif
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 COMP,
  input  logic                 ENABLE,
  output logic [DW-1:0]        DATA,
  output logic                 DATA_VALID,
  input  logic                 DATA_READ,
  output logic [CNT_WIDTH-1:0] HIT_CNT,
  input  logic                 CNT_CLR,
  output logic                 OVERFLOW,
  output logic                 BUSY
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [TOT_WIDTH-1:0] TOT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, MEASURE, STORE} state_t;

  state_t state, next_state;

  logic                 sync1, comp_s, comp_d;
  logic [1:0]           primed;
  logic                 armed, rise;
  logic                 start, store;
  logic [TOT_WIDTH-1:0] tot;
  logic [DW-1:0]        entry;
  logic [DW-1:0]        mem [FIFO_DEPTH];
  logic [PW:0]          wr_ptr, rd_ptr;
  logic                 full, pop, push, drop;
  logic [CNT_WIDTH-1:0] hit_cnt;
  logic                 overflow;

  // Synchroniser plus arming. The synchroniser stages come out of reset at 0,
  // which says nothing about the real COMP level, so "primed" masks the first
  // two cycles: armed is only set by a genuine low level of COMP. This keeps a
  // pulse that was already high through reset from being counted.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1  <= 1'b0;
      comp_s <= 1'b0;
      comp_d <= 1'b0;
      primed <= 2'b00;
      armed  <= 1'b0;
    end else begin
      sync1  <= COMP;
      comp_s <= sync1;
      comp_d <= comp_s;
      primed <= {primed[0], 1'b1};
      if (primed[1] && !comp_s)
        armed <= 1'b1;
    end
  end

  assign rise = comp_s & ~comp_d;

  always_ff @(posedge CLK) begin
    if (RESET)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    start      = 1'b0;
    store      = 1'b0;
    case (state)
      IDLE: begin
        if (ENABLE && armed && rise) begin
          next_state = MEASURE;
          start      = 1'b1;
        end
      end
      MEASURE: begin
        if (!comp_s)
          next_state = STORE;
      end
      STORE: begin
        store      = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The start edge already counts as one cycle over threshold.
  always_ff @(posedge CLK) begin
    if (RESET)
      tot <= '0;
    else if (start)
      tot <= TOT_WIDTH'(1);
    else if (state == MEASURE && comp_s && tot != TOT_MAX)
      tot <= tot + TOT_WIDTH'(1);
  end

`ifdef AFE_TOT_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt, ts_cap;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ts_cnt <= '0;
      ts_cap <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_WIDTH'(1);
      if (start)
        ts_cap <= ts_cnt;
    end
  end

  assign entry = {ts_cap, tot};
`else
  assign entry = tot;
`endif

  // FIFO with an extra wrap bit on each pointer to tell full from empty.
  // A pop in the STORE cycle frees the slot being written, so a full FIFO
  // still accepts the new result.
  assign DATA_VALID = (wr_ptr != rd_ptr);
  assign full       = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop        = DATA_READ & DATA_VALID;
  assign push       = store & (~full | pop);
  assign drop       = store & full & ~pop;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)
        rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push)
      mem[wr_ptr[PW-1:0]] <= entry;
  end

  assign DATA = DATA_VALID ? mem[rd_ptr[PW-1:0]] : '0;

  // A clear coinciding with STORE keeps that STORE's hit and drop flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_cnt  <= '0;
      overflow <= 1'b0;
    end else if (CNT_CLR) begin
      hit_cnt  <= store ? CNT_WIDTH'(1) : '0;
      overflow <= drop;
    end else begin
      if (store && hit_cnt != CNT_MAX)
        hit_cnt <= hit_cnt + CNT_WIDTH'(1);
      if (drop)
        overflow <= 1'b1;
    end
  end

  assign HIT_CNT  = hit_cnt;
  assign OVERFLOW = overflow;
  assign BUSY     = (state == MEASURE);

endmodule

// File: tb/tb_afe_tot_meter.sv
// tb_afe_tot_meter
//   Self-checking bench for afe_tot_meter. Pulses are described at the pulse
//   level (length, enable, read during store) and a queue-based model predicts
//   FIFO contents, hit count and overflow. Inputs change 1 time unit after a
//   rising edge (or on the falling edge); outputs are checked on the falling edge.
//   With AFE_TOT_TIMESTAMP_EN only the ToT field of DATA is compared.
module tb_afe_tot_meter;

  localparam int TOT_W = 8;
  localparam int CNT_W = 16;
  localparam int DEPTH = 4;
`ifdef AFE_TOT_TIMESTAMP_EN
  localparam int DW = 16 + TOT_W;
`else
  localparam int DW = TOT_W;
`endif

  logic             CLK = 1'b0;
  logic             RESET;
  logic             COMP;
  logic             ENABLE;
  logic [DW-1:0]    DATA;
  logic             DATA_VALID;
  logic             DATA_READ;
  logic [CNT_W-1:0] HIT_CNT;
  logic             CNT_CLR;
  logic             OVERFLOW;
  logic             BUSY;

  int checks = 0;
  int fails  = 0;

  int model_q[$];
  int hits;
  bit ovf;

  afe_tot_meter #(
    .TOT_WIDTH (TOT_W),
    .CNT_WIDTH (CNT_W),
    .FIFO_DEPTH(DEPTH),
    .TS_WIDTH  (16)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .COMP      (COMP),
    .ENABLE    (ENABLE),
    .DATA      (DATA),
    .DATA_VALID(DATA_VALID),
    .DATA_READ (DATA_READ),
    .HIT_CNT   (HIT_CNT),
    .CNT_CLR   (CNT_CLR),
    .OVERFLOW  (OVERFLOW),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkState();
    @(negedge CLK);
    checkOutput("data_valid", {31'b0, DATA_VALID}, {31'b0, model_q.size() != 0});
    if (model_q.size() != 0)
      checkOutput("data_head", {24'b0, DATA[TOT_W-1:0]}, model_q[0]);
    checkOutput("hit_cnt", {16'b0, HIT_CNT}, hits);
    checkOutput("overflow", {31'b0, OVERFLOW}, {31'b0, ovf});
    checkOutput("busy_idle", {31'b0, BUSY}, 0);
  endtask

  task automatic doReset();
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    model_q.delete();
    hits = 0;
    ovf  = 1'b0;
    checkState();
    checkOutput("reset_data", {8'b0, DATA}, 0);
    repeat (5) @(posedge CLK);
    #1;
  endtask

  // One COMP pulse covering exactly len rising edges. ENABLE follows en,
  // optionally dropping mid-measurement; DATA_READ may be asserted in the
  // cycle the result is stored.
  task automatic applyStimulus(input int len, input bit en, input bit drop_en, input bit read_in_store);
    int tot;
    ENABLE = en;
    COMP   = 1'b1;
    for (int i = 1; i <= len; i++) begin
      @(posedge CLK);
      #1;
      if (en && i == 4)
        checkOutput("busy_measure", {31'b0, BUSY}, 1);
      if (drop_en && i == 5)
        ENABLE = 1'b0;
    end
    COMP = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    if (read_in_store) begin
      if (model_q.size() != 0)
        checkOutput("store_head", {24'b0, DATA[TOT_W-1:0]}, model_q[0]);
      DATA_READ = 1'b1;
    end
    @(posedge CLK);
    #1 DATA_READ = 1'b0;
    ENABLE = 1'b1;
    if (read_in_store && model_q.size() != 0)
      void'(model_q.pop_front());
    if (en) begin
      tot = (len > 255) ? 255 : len;
      if (model_q.size() < DEPTH)
        model_q.push_back(tot);
      else
        ovf = 1'b1;
      if (hits != 65535)
        hits++;
    end
    repeat (2) @(posedge CLK);
    checkState();
  endtask

  task automatic readOne();
    DATA_READ = 1'b1;
    @(posedge CLK);
    #1 DATA_READ = 1'b0;
    if (model_q.size() != 0)
      void'(model_q.pop_front());
    checkState();
  endtask

  task automatic clearCounts();
    CNT_CLR = 1'b1;
    @(posedge CLK);
    #1 CNT_CLR = 1'b0;
    hits = 0;
    ovf  = 1'b0;
    checkState();
  endtask

  initial begin
    int len;
    int sel;
    RESET     = 1'b1;
    COMP      = 1'b0;
    ENABLE    = 1'b0;
    DATA_READ = 1'b0;
    CNT_CLR   = 1'b0;
    hits      = 0;
    ovf       = 1'b0;

    $display("[TB] reset and single 10-cycle pulse");
    doReset();
    ENABLE = 1'b1;
    applyStimulus(10, 1'b1, 1'b0, 1'b0);

    $display("[TB] ToT saturation");
    doReset();
    applyStimulus(300, 1'b1, 1'b0, 1'b0);

    $display("[TB] FIFO fill and drop, then counter clear");
    doReset();
    for (int l = 3; l <= 7; l++)
      applyStimulus(l, 1'b1, 1'b0, 1'b0);
    clearCounts();

    $display("[TB] read during store on a full FIFO");
    applyStimulus(9, 1'b1, 1'b0, 1'b1);
    repeat (4) readOne();
    readOne();

    $display("[TB] enable handling");
    applyStimulus(8, 1'b0, 1'b0, 1'b0);
    applyStimulus(12, 1'b1, 1'b1, 1'b0);
    readOne();

    $display("[TB] randomized traffic");
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5) begin
        len = $urandom_range(1, 40);
        applyStimulus(len, ($urandom_range(0, 4) != 0),
                      (len >= 6) && ($urandom_range(0, 4) == 0),
                      ($urandom_range(0, 2) == 0));
      end else if (sel < 9) begin
        readOne();
      end else begin
        clearCounts();
      end
    end

    $display("[TB] reset during measurement with COMP held high");
    applyStimulus(6, 1'b1, 1'b0, 1'b0);
    COMP   = 1'b1;
    ENABLE = 1'b1;
    repeat (6) @(posedge CLK);
    #1;
    checkOutput("busy_before_reset", {31'b0, BUSY}, 1);
    doReset();
    repeat (8) @(posedge CLK);
    #1 COMP = 1'b0;
    repeat (8) @(posedge CLK);
    checkState();
    applyStimulus(5, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
